alu_sequencer: RTL and testbench

// - Control side of the 64-bit ALU: fetches 64-bit instruction words, decodes them into ALU

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_seq_decode.sv | 19 +
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, instruction field positions and FSM states for the ALU sequencer
package alu_pkg;

  localparam logic [5:0] OP_ADD        = 6'd0;
  localparam logic [5:0] OP_REG_LAST   = 6'd5;
  localparam logic [5:0] OP_FLAG_FIRST = 6'd8;
  localparam logic [5:0] OP_FLAG_LAST  = 6'd13;
  localparam logic [5:0] OP_MUL        = 6'd16;
  localparam logic [5:0] OP_DIV        = 6'd17;
  localparam logic [5:0] OP_HALT       = 6'd63;

  localparam int IR_OP_HI  = 63;
  localparam int IR_OP_LO  = 58;
  localparam int IR_WA_HI  = 57;
  localparam int IR_WA_LO  = 54;
  localparam int IR_RA_HI  = 53;
  localparam int IR_RA_LO  = 50;
  localparam int IR_RB_HI  = 49;
  localparam int IR_RB_LO  = 46;
  localparam int IR_HL     = 45;
  localparam int IR_VAL_HI = 31;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WAIT,
    WB,
    HALT
  } state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - opcode classification for the ALU sequencer
module alu_seq_decode
  import alu_pkg::*;
(
  input  logic [5:0] op_i,
  output logic       writes_reg_o,
  output logic       writes_flag_o,
  output logic       is_muldiv_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  assign is_muldiv_o   = (op_i == OP_MUL) || (op_i == OP_DIV);
  assign writes_reg_o  = (op_i <= OP_REG_LAST) || is_muldiv_o;
  assign writes_flag_o = (op_i >= OP_FLAG_FIRST) && (op_i <= OP_FLAG_LAST);
  assign is_halt_o     = (op_i == OP_HALT);
  assign is_illegal_o  = (op_i > OP_DIV) && (op_i < OP_HALT);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/writeback control for the 64-bit ALU
// Define ALU_SEQ_ILLEGAL_TRAP_EN to halt on opcodes 18..62 instead of treating them as NOPs.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MULDIV_WAIT = 4,
  parameter int          NREG        = 16,
  localparam int         RAW         = $clog2(NREG)
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           start,
  output logic           imem_req,
  output logic [63:0]    imem_addr,
  input  logic           imem_ack,
  input  logic [63:0]    imem_data,
  output logic [RAW-1:0] rf_raddr_a,
  output logic [RAW-1:0] rf_raddr_b,
  output logic           rf_we,
  output logic [RAW-1:0] rf_waddr,
  output logic [63:0]    rf_wdata,
  output logic [5:0]     alu_instr,
  output logic [31:0]    alu_value,
  output logic           alu_highlow,
  output logic           alu_f1,
  output logic           alu_f2,
  input  logic [63:0]    alu_c,
  input  logic           alu_f3,
  input  logic           alu_addrch,
  input  logic [63:0]    alu_naddr,
  output logic           busy,
  output logic           halted
);

  localparam int CW = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;

  state_e        state_q;
  logic [63:0]   pc_q;
  logic [63:0]   ir_q;
  logic          f1_q, f2_q;
  logic [CW-1:0] wait_cnt_q;
  logic          imem_req_q;
  logic          rf_we_q;
  logic [63:0]   rf_wdata_q;
  logic          halted_q;

  logic dec_wr, dec_flag, dec_muldiv, dec_halt, dec_illegal, halt_now;

  alu_seq_decode u_decode (
    .op_i          (ir_q[IR_OP_HI:IR_OP_LO]),
    .writes_reg_o  (dec_wr),
    .writes_flag_o (dec_flag),
    .is_muldiv_o   (dec_muldiv),
    .is_halt_o     (dec_halt),
    .is_illegal_o  (dec_illegal)
  );

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign halt_now = dec_halt | dec_illegal;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign halt_now       = dec_halt;
`endif

  logic [12:0] unused_ir;
  assign unused_ir = ir_q[44:32];

  // rf_wdata is captured on the edge into WB so it is valid during the write strobe.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      f1_q       <= 1'b0;
      f2_q       <= 1'b0;
      wait_cnt_q <= '0;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wdata_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            imem_req_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir_q       <= imem_data;
            imem_req_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (dec_muldiv && (MULDIV_WAIT > 0)) begin
            state_q    <= WAIT;
            wait_cnt_q <= CW'(MULDIV_WAIT - 1);
          end else begin
            state_q    <= WB;
            rf_we_q    <= dec_wr;
            rf_wdata_q <= alu_c;
          end
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q    <= WB;
            rf_we_q    <= dec_wr;
            rf_wdata_q <= alu_c;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        WB: begin
          if (halt_now) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q    <= FETCH;
            imem_req_q <= 1'b1;
            if (dec_flag) begin
              f2_q <= f1_q;
              f1_q <= alu_f3;
            end
            pc_q <= alu_addrch ? alu_naddr : pc_q + 64'd8;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign rf_raddr_a  = RAW'(ir_q[IR_RA_HI:IR_RA_LO]);
  assign rf_raddr_b  = RAW'(ir_q[IR_RB_HI:IR_RB_LO]);
  assign rf_waddr    = RAW'(ir_q[IR_WA_HI:IR_WA_LO]);
  assign rf_we       = rf_we_q;
  assign rf_wdata    = rf_wdata_q;
  assign alu_instr   = ir_q[IR_OP_HI:IR_OP_LO];
  assign alu_value   = ir_q[IR_VAL_HI:0];
  assign alu_highlow = ir_q[IR_HL];
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign busy        = (state_q != IDLE) && (state_q != HALT);
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and random checks of alu_sequencer against a behavioural model
module tb_alu_sequencer;

  localparam logic [63:0] RESET_PC    = 64'h0;
  localparam int          MULDIV_WAIT = 4;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [63:0] imem_data = '0;
  logic [63:0] alu_c = '0;
  logic        alu_f3 = 1'b0;
  logic        alu_addrch = 1'b0;
  logic [63:0] alu_naddr = '0;

  logic        imem_req, rf_we, alu_highlow, alu_f1, alu_f2, busy, halted;
  logic [63:0] imem_addr, rf_wdata;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [5:0]  alu_instr;
  logic [31:0] alu_value;

  alu_sequencer #(
    .RESET_PC    (RESET_PC),
    .MULDIV_WAIT (MULDIV_WAIT),
    .NREG        (16)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_instr   (alu_instr),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_c       (alu_c),
    .alu_f3      (alu_f3),
    .alu_addrch  (alu_addrch),
    .alu_naddr   (alu_naddr),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  logic [63:0] m_pc = RESET_PC;
  logic        m_f1 = 1'b0;
  logic        m_f2 = 1'b0;
  logic        m_halted = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("fetch_req_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_pc     = RESET_PC;
    m_halted = 1'b0;
  endtask

  // Acts as instruction memory and ALU for one instruction, then advances the model.
  task automatic run_instr(input logic [5:0] op, input logic [3:0] wa, input logic [3:0] ra,
                           input logic [3:0] rb, input logic hl, input logic [31:0] val,
                           input logic [63:0] c, input logic f3, input logic ach,
                           input logic [63:0] na, input int dly, input bit poke);
    logic [63:0] ir;
    bit wr, fl, hlt;
    int w;
    ir  = {op, wa, ra, rb, hl, 13'd0, val};
    wr  = (op <= 6'd5) || (op == 6'd16) || (op == 6'd17);
    fl  = (op >= 6'd8) && (op <= 6'd13);
    hlt = (op == 6'd63);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if ((op >= 6'd18) && (op <= 6'd62)) hlt = 1'b1;
`endif
    w = ((op == 6'd16) || (op == 6'd17)) ? MULDIV_WAIT : 0;

    wait_req();
    check("fetch_addr", imem_addr, m_pc);
    repeat (dly) @(negedge clock);
    check("req_held", {63'd0, imem_req}, 64'd1);
    imem_ack   = 1'b1;
    imem_data  = ir;
    alu_c      = c;
    alu_f3     = f3;
    alu_addrch = ach;
    alu_naddr  = na;
    @(negedge clock);
    imem_ack  = 1'b0;
    imem_data = {$urandom, $urandom};

    check("exec_instr", {58'd0, alu_instr}, {58'd0, op});
    check("exec_value", {32'd0, alu_value}, {32'd0, val});
    check("exec_highlow", {63'd0, alu_highlow}, {63'd0, hl});
    check("exec_raddr_a", {60'd0, rf_raddr_a}, {60'd0, ra});
    check("exec_raddr_b", {60'd0, rf_raddr_b}, {60'd0, rb});
    check("exec_waddr", {60'd0, rf_waddr}, {60'd0, wa});
    check("exec_busy", {63'd0, busy}, 64'd1);
    check("exec_req_low", {63'd0, imem_req}, 64'd0);
    check("exec_no_we", {63'd0, rf_we}, 64'd0);
    if (poke) start = 1'b1;

    for (int i = 0; i < w; i++) begin
      @(negedge clock);
      start = 1'b0;
      check("wait_no_we", {63'd0, rf_we}, 64'd0);
    end
    @(negedge clock);
    start = 1'b0;
    check("wb_we", {63'd0, rf_we}, {63'd0, wr});
    if (wr) check("wb_wdata", rf_wdata, c);

    @(negedge clock);
    if (hlt) begin
      m_halted = 1'b1;
    end else begin
      if (fl) begin
        m_f2 = m_f1;
        m_f1 = f3;
      end
      m_pc = ach ? na : m_pc + 64'd8;
    end
    check("post_we", {63'd0, rf_we}, 64'd0);
    check("post_f1", {63'd0, alu_f1}, {63'd0, m_f1});
    check("post_f2", {63'd0, alu_f2}, {63'd0, m_f2});
    check("post_halted", {63'd0, halted}, {63'd0, m_halted});
    check("post_busy", {63'd0, busy}, {63'd0, !m_halted});
    check("post_req", {63'd0, imem_req}, {63'd0, !m_halted});
  endtask

  initial begin
    logic [5:0] rop;

    repeat (2) @(negedge clock);
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_we", {63'd0, rf_we}, 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_instr", {58'd0, alu_instr}, 64'd0);
    check("rst_flags", {62'd0, alu_f1, alu_f2}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    rst_n = 1'b1;
    @(negedge clock);
    check("idle_no_req", {63'd0, imem_req}, 64'd0);

    do_start();
    run_instr(6'd0, 4'd3, 4'd1, 4'd2, 1'b0, 32'h1234, 64'h5, 1'b1, 1'b0, 64'h0, 3, 1'b0);
    run_instr(6'd8, 4'd0, 4'd4, 4'd5, 1'b1, 32'h0, 64'hA, 1'b1, 1'b0, 64'h0, 0, 1'b0);
    run_instr(6'd9, 4'd0, 4'd6, 4'd7, 1'b0, 32'h0, 64'hB, 1'b0, 1'b0, 64'h0, 1, 1'b0);
    run_instr(6'd15, 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 64'h100, 0, 1'b0);
    run_instr(6'd15, 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 64'h200, 2, 1'b0);
    run_instr(6'd14, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b0);
    run_instr(6'd16, 4'd9, 4'd10, 4'd11, 1'b1, 32'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0,
              1'b1, 1'b0, 64'h0, 1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      rop = 6'($urandom_range(0, 17));
      run_instr(rop, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom,
                {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 3) == 0),
                {$urandom, $urandom} & ~64'h7, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    run_instr(6'd20, 4'd7, 4'd1, 4'd1, 1'b0, 32'h55, 64'h77, 1'b1, 1'b0, 64'h0, 0, 1'b0);
    if (m_halted) do_start();
    run_instr(6'd63, 4'd2, 4'd1, 4'd1, 1'b0, 32'h0, 64'h99, 1'b1, 1'b1, 64'h300, 0, 1'b0);
    repeat (3) @(negedge clock);
    check("halt_stays", {62'd0, halted, busy}, 64'd2);

    do_start();
    wait_req();
    check("restart_addr", imem_addr, RESET_PC);
    #2 rst_n = 1'b0;
    #1 check("async_req_drop", {63'd0, imem_req}, 64'd0);
    check("async_busy_drop", {63'd0, busy}, 64'd0);
    @(negedge clock);
    imem_ack  = 1'b1;
    imem_data = {6'd1, 58'h3FF};
    rst_n     = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    @(negedge clock);
    check("late_ack_busy", {63'd0, busy}, 64'd0);
    check("late_ack_req", {63'd0, imem_req}, 64'd0);
    check("late_ack_ir", {58'd0, alu_instr}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
